conv_frame_sequencer: RTL and testbench

// - Frame-level controller for one RGB 3x3 convolution layer.
// - Pulses the weight load, then gates an RGB pixel stream from an upstream source into the RGB window generator.
// - Waits for the window generator's done before reporting frame completion; it is the layer's only control source.

---
 rtl/conv_frame_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_conv_frame_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : conv_frame_sequencer
// Brief    : Frame controller for an RGB 3x3 conv layer: weight-load strobe,
//            gated pixel stream, drain wait with timeout. Optional
//            CONV_SEQ_PERF_EN adds a cycle_cnt performance counter.
// Revision : 1.0 - initial release
// ============================================================================
module conv_frame_sequencer #(
    parameter int DATA_WIDTH    = 8,
    parameter int IMG_W         = 28,
    parameter int IMG_H         = 28,
    parameter int WLOAD_CYCLES  = 9,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      src_valid,
    output logic                      src_ready,
    input  logic [DATA_WIDTH-1:0]     src_r,
    input  logic [DATA_WIDTH-1:0]     src_g,
    input  logic [DATA_WIDTH-1:0]     src_b,
    output logic                      load_weight,
    output logic [DATA_WIDTH-1:0]     pixel_in_r,
    output logic [DATA_WIDTH-1:0]     pixel_in_g,
    output logic [DATA_WIDTH-1:0]     pixel_in_b,
    output logic                      pixel_valid,
    input  logic                      win_done,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      timeout_err,
    output logic [$clog2(IMG_H)-1:0]  row,
    output logic [$clog2(IMG_W)-1:0]  col
`ifdef CONV_SEQ_PERF_EN
    ,
    output logic [31:0]               cycle_cnt
`endif
);

    localparam int c_ROW_W  = $clog2(IMG_H);
    localparam int c_COL_W  = $clog2(IMG_W);
    localparam int c_WCNT_W = $clog2(WLOAD_CYCLES + 1);
    localparam int c_DCNT_W = $clog2(DRAIN_TIMEOUT + 1);

    localparam logic [c_ROW_W-1:0]  c_ROW_LAST  = c_ROW_W'(IMG_H - 1);
    localparam logic [c_COL_W-1:0]  c_COL_LAST  = c_COL_W'(IMG_W - 1);
    localparam logic [c_WCNT_W-1:0] c_WCNT_LAST = c_WCNT_W'(WLOAD_CYCLES - 1);
    localparam logic [c_DCNT_W-1:0] c_DCNT_LAST = c_DCNT_W'(DRAIN_TIMEOUT - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_LOAD_W = 3'd1;
    localparam logic [2:0] c_STREAM = 3'd2;
    localparam logic [2:0] c_DRAIN  = 3'd3;
    localparam logic [2:0] c_DONE   = 3'd4;

    logic [2:0]            r_state;
    logic [c_WCNT_W-1:0]   r_wcnt;
    logic [c_DCNT_W-1:0]   r_dcnt;
    logic [c_ROW_W-1:0]    r_row;
    logic [c_COL_W-1:0]    r_col;
    logic                  r_src_ready;
    logic                  r_load_weight;
    logic [DATA_WIDTH-1:0] r_pix_r;
    logic [DATA_WIDTH-1:0] r_pix_g;
    logic [DATA_WIDTH-1:0] r_pix_b;
    logic                  r_pixel_valid;
    logic                  r_busy;
    logic                  r_frame_done;
    logic                  r_timeout_err;
    logic                  w_hs;

    assign w_hs = src_valid & r_src_ready;

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            r_state       <= c_IDLE;
            r_wcnt        <= '0;
            r_dcnt        <= '0;
            r_row         <= '0;
            r_col         <= '0;
            r_src_ready   <= 1'b0;
            r_load_weight <= 1'b0;
            r_pix_r       <= '0;
            r_pix_g       <= '0;
            r_pix_b       <= '0;
            r_pixel_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            // The error flag survives abort so software can still inspect it
            if (rst) r_timeout_err <= 1'b0;
        end else begin
            r_frame_done  <= 1'b0;
            r_pixel_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state       <= c_LOAD_W;
                        r_load_weight <= 1'b1;
                        r_busy        <= 1'b1;
                        r_wcnt        <= '0;
                        r_timeout_err <= 1'b0;
                    end
                end
                c_LOAD_W: begin
                    if (r_wcnt == c_WCNT_LAST) begin
                        r_state       <= c_STREAM;
                        r_load_weight <= 1'b0;
                        r_src_ready   <= 1'b1;
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                c_STREAM: begin
                    if (w_hs) begin
                        r_pix_r       <= src_r;
                        r_pix_g       <= src_g;
                        r_pix_b       <= src_b;
                        r_pixel_valid <= 1'b1;
                        if (r_col == c_COL_LAST) begin
                            r_col <= '0;
                            if (r_row == c_ROW_LAST) begin
                                r_row       <= '0;
                                r_state     <= c_DRAIN;
                                r_src_ready <= 1'b0;
                                r_dcnt      <= '0;
                            end else begin
                                r_row <= r_row + 1'b1;
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                c_DRAIN: begin
                    // win_done is checked first so a same-cycle timeout is not an error
                    if (win_done) begin
                        r_state      <= c_DONE;
                        r_frame_done <= 1'b1;
                    end else if (r_dcnt == c_DCNT_LAST) begin
                        r_state       <= c_DONE;
                        r_frame_done  <= 1'b1;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign src_ready   = r_src_ready;
    assign load_weight = r_load_weight;
    assign pixel_in_r  = r_pix_r;
    assign pixel_in_g  = r_pix_g;
    assign pixel_in_b  = r_pix_b;
    assign pixel_valid = r_pixel_valid;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign timeout_err = r_timeout_err;
    assign row         = r_row;
    assign col         = r_col;

`ifdef CONV_SEQ_PERF_EN
    logic [31:0] r_cycle_cnt;

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            r_cycle_cnt <= '0;
        end else if (r_state == c_IDLE && start) begin
            r_cycle_cnt <= '0;
        end else if (r_state == c_LOAD_W || r_state == c_STREAM || r_state == c_DRAIN) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
    end

    assign cycle_cnt = r_cycle_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_frame_sequencer
// Brief    : Directed self-checking bench for conv_frame_sequencer (4x4 frame).
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_frame_sequencer;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int WL = 9;
    localparam int DT = 32;

    logic          clk = 1'b0;
    logic          rst, start, abort, src_valid, win_done;
    logic [DW-1:0] src_r, src_g, src_b;
    logic          src_ready, load_weight, pixel_valid, busy, frame_done, timeout_err;
    logic [DW-1:0] pixel_in_r, pixel_in_g, pixel_in_b;
    logic [1:0]    row, col;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv_frame_sequencer #(
        .DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .WLOAD_CYCLES(WL), .DRAIN_TIMEOUT(DT)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_r(src_r), .src_g(src_g), .src_b(src_b),
        .load_weight(load_weight),
        .pixel_in_r(pixel_in_r), .pixel_in_g(pixel_in_g), .pixel_in_b(pixel_in_b),
        .pixel_valid(pixel_valid), .win_done(win_done), .busy(busy),
        .frame_done(frame_done), .timeout_err(timeout_err), .row(row), .col(col)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; abort = 1'b0; src_valid = 1'b0; win_done = 1'b0;
        src_r = 8'hAA; src_g = 8'hBB; src_b = 8'hCC;
        tick(); tick();
        checks++;
        if ({busy, src_ready, load_weight, pixel_valid, frame_done, timeout_err, row, col,
             pixel_in_r, pixel_in_g, pixel_in_b} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b rdy=%b lw=%b pv=%b fd=%b te=%b row=%0d col=%0d pix=%h/%h/%h required all zero",
                     busy, src_ready, load_weight, pixel_valid, frame_done, timeout_err, row, col,
                     pixel_in_r, pixel_in_g, pixel_in_b);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || load_weight !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b lw=%b required 0 0", busy, load_weight);
        end
    endtask

    task automatic test_load_weight;
        start_frame();
        for (int i = 0; i < WL; i++) begin
            checks++;
            if (load_weight !== 1'b1 || src_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL load_w_cycle%0d: lw=%b rdy=%b busy=%b required 1 0 1", i, load_weight, src_ready, busy);
            end
            tick();
        end
        checks++;
        if (load_weight !== 1'b0 || src_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_w_end: lw=%b rdy=%b required 0 1", load_weight, src_ready);
        end
    endtask

    task automatic test_back_to_back;
        for (int k = 1; k <= W * H; k++) begin
            src_valid = 1'b1;
            src_r = DW'(k); src_g = DW'(k + 32); src_b = DW'(k + 64);
            tick();
            checks++;
            if (pixel_valid !== 1'b1 || pixel_in_r !== DW'(k) || pixel_in_g !== DW'(k + 32) ||
                pixel_in_b !== DW'(k + 64) || col !== 2'((k % W)) || row !== 2'(((k / W) % H))) begin
                errors++;
                $display("FAIL b2b_pix%0d: pv=%b pix=%h/%h/%h row=%0d col=%0d required 1 %h/%h/%h %0d %0d",
                         k, pixel_valid, pixel_in_r, pixel_in_g, pixel_in_b, row, col,
                         DW'(k), DW'(k + 32), DW'(k + 64), (k / W) % H, k % W);
            end
        end
        src_valid = 1'b0;
        checks++;
        if (src_ready !== 1'b0 || row !== 2'd0 || col !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_enter_drain: rdy=%b row=%0d col=%0d busy=%b required 0 0 0 1", src_ready, row, col, busy);
        end
    endtask

    task automatic test_drain_done;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (frame_done !== 1'b0 || pixel_valid !== 1'b0 || src_ready !== 1'b0) begin
                errors++;
                $display("FAIL drain_wait%0d: fd=%b pv=%b rdy=%b required 0 0 0", i, frame_done, pixel_valid, src_ready);
            end
        end
        win_done = 1'b1;
        tick();
        win_done = 1'b0;
        checks++;
        if (frame_done !== 1'b1 || timeout_err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL drain_done_pulse: fd=%b te=%b busy=%b required 1 0 1", frame_done, timeout_err, busy);
        end
        tick();
        checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL drain_back_idle: fd=%b busy=%b required 0 0", frame_done, busy);
        end
    endtask

    task automatic test_backpressure;
        int n;
        logic [DW-1:0] last;
        logic exp_v;
        n = 0;
        last = DW'(16);
        start_frame();
        repeat (WL) tick();
        win_done = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_v = (i % 2 == 0);
            src_valid = exp_v;
            src_r = DW'(128 + i);
            tick();
            if (exp_v) begin
                last = DW'(128 + i);
                n++;
            end
            checks++;
            if (pixel_valid !== exp_v || pixel_in_r !== last || col !== 2'((n % W)) ||
                row !== 2'((n / W)) || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL bp_step%0d: pv=%b pix=%h row=%0d col=%0d fd=%b required %b %h %0d %0d 0",
                         i, pixel_valid, pixel_in_r, row, col, frame_done, exp_v, last, n / W, n % W);
            end
        end
        win_done = 1'b0;
        for (int k = 0; k < W * H - 4; k++) begin
            src_valid = 1'b1;
            src_r = DW'(k);
            tick();
        end
        src_valid = 1'b0;
        checks++;
        if (src_ready !== 1'b0 || busy !== 1'b1 || row !== 2'd0 || col !== 2'd0) begin
            errors++;
            $display("FAIL bp_enter_drain: rdy=%b busy=%b row=%0d col=%0d required 0 1 0 0", src_ready, busy, row, col);
        end
    endtask

    task automatic test_timeout;
        for (int j = 1; j < DT; j++) begin
            tick();
            checks++;
            if (frame_done !== 1'b0 || timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait%0d: fd=%b te=%b required 0 0", j, frame_done, timeout_err);
            end
        end
        tick();
        checks++;
        if (frame_done !== 1'b1 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_fire: fd=%b te=%b required 1 1", frame_done, timeout_err);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: busy=%b fd=%b te=%b required 0 0 1", busy, frame_done, timeout_err);
        end
        start_frame();
        checks++;
        if (timeout_err !== 1'b0 || load_weight !== 1'b1) begin
            errors++;
            $display("FAIL timeout_clear_on_start: te=%b lw=%b required 0 1", timeout_err, load_weight);
        end
    endtask

    task automatic test_abort;
        // Second start mid-LOAD_W must not stretch the strobe
        for (int i = 1; i < WL; i++) begin
            start = (i == 4);
            tick();
            checks++;
            if (load_weight !== 1'b1) begin
                errors++;
                $display("FAIL abort_lw_busy_start%0d: lw=%b required 1", i, load_weight);
            end
        end
        start = 1'b0;
        tick();
        checks++;
        if (load_weight !== 1'b0 || src_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_lw_len: lw=%b rdy=%b required 0 1", load_weight, src_ready);
        end
        for (int k = 1; k <= 7; k++) begin
            src_valid = 1'b1;
            src_r = DW'(48 + k);
            tick();
        end
        checks++;
        if (row !== 2'd1 || col !== 2'd3 || pixel_in_r !== 8'h37) begin
            errors++;
            $display("FAIL abort_pre_pos: row=%0d col=%0d pix=%h required 1 3 37", row, col, pixel_in_r);
        end
        abort = 1'b1; start = 1'b1; src_r = 8'hFF;
        tick();
        abort = 1'b0; start = 1'b0; src_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || src_ready !== 1'b0 || pixel_valid !== 1'b0 || row !== 2'd0 ||
            col !== 2'd0 || load_weight !== 1'b0 || pixel_in_r !== 8'h00) begin
            errors++;
            $display("FAIL abort_idle: busy=%b rdy=%b pv=%b row=%0d col=%0d lw=%b pix=%h required 0 0 0 0 0 0 00",
                     busy, src_ready, pixel_valid, row, col, load_weight, pixel_in_r);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || load_weight !== 1'b0) begin
            errors++;
            $display("FAIL abort_beats_start: busy=%b lw=%b required 0 0", busy, load_weight);
        end
        start_frame();
        checks++;
        if (load_weight !== 1'b1 || row !== 2'd0 || col !== 2'd0) begin
            errors++;
            $display("FAIL abort_restart: lw=%b row=%0d col=%0d required 1 0 0", load_weight, row, col);
        end
        repeat (WL) tick();
        src_valid = 1'b1;
        src_r = 8'h5A;
        tick();
        src_valid = 1'b0;
        checks++;
        if (pixel_valid !== 1'b1 || pixel_in_r !== 8'h5A || row !== 2'd0 || col !== 2'd1) begin
            errors++;
            $display("FAIL abort_first_pixel: pv=%b pix=%h row=%0d col=%0d required 1 5a 0 1",
                     pixel_valid, pixel_in_r, row, col);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_weight();
        test_back_to_back();
        test_drain_done();
        test_backpressure();
        test_timeout();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
